// File: rtl/ascon_sequencer.sv
// Ascon permutation sequencer: one operation per start, s_init 1 cycle after start, first round 2 cycles after.
// Outputs registered except s_absorb; stalls in ABS until blk_valid and in SQZ until out_ready; start ignored while busy.
module ascon_sequencer #(
    parameter int ROUNDS_A        = 12,
    parameter int ROUNDS_B        = 8,
    parameter int HASH_OUT_BLOCKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] operation_mode,
    input  logic       start,
    input  logic       blk_valid,
    input  logic       blk_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       s_init,
    output logic       perm_en,
    output logic [3:0] round_idx,
    output logic       key_xor_init,
    output logic       key_xor_final,
    output logic       blk_ready,
    output logic       s_absorb,
    output logic       out_valid,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_PERM, S_KEYI, S_ABS, S_KEYF, S_SQZ, S_FIN
    } state_t;

    // What follows the current permutation.
    typedef enum logic [1:0] {
        PH_INIT, PH_DATA, PH_SQZ
    } phase_t;

    localparam logic [3:0] IDX_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] IDX_B    = 4'(12 - ROUNDS_B);
    localparam logic [3:0] IDX_LAST = 4'd11;
    localparam logic [3:0] N_OUT    = 4'(HASH_OUT_BLOCKS);

    state_t     r_state;
    phase_t     r_phase;
    logic [2:0] r_mode;
    logic [3:0] r_round_idx;
    logic [3:0] r_out_cnt;
    logic       r_busy;
    logic       r_s_init;
    logic       r_perm_en;
    logic       r_key_xor_init;
    logic       r_key_xor_final;
    logic       r_blk_ready;
    logic       r_out_valid;
    logic       r_done;
    logic       r_err;

    state_t     w_nxt_state;
    phase_t     w_nxt_phase;
    logic [2:0] w_nxt_mode;
    logic [3:0] w_nxt_idx;
    logic [3:0] w_nxt_out_cnt;
    logic       w_nxt_err;
    logic       w_aead;
    logic       w_hs;
    logic [3:0] w_cnt_inc;

    assign w_aead    = (r_mode == 3'd1) || (r_mode == 3'd2);
    assign w_hs      = blk_valid & r_blk_ready;
    assign w_cnt_inc = r_out_cnt + 4'd1;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_phase   = r_phase;
        w_nxt_mode    = r_mode;
        w_nxt_idx     = 4'd0;
        w_nxt_out_cnt = r_out_cnt;
        w_nxt_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (operation_mode >= 3'd6) begin
                        w_nxt_err = 1'b1;
                    end else if (operation_mode != 3'd0) begin
                        w_nxt_mode    = operation_mode;
                        w_nxt_out_cnt = 4'd0;
                        w_nxt_state   = S_INIT;
                    end
                end
            end
            S_INIT: begin
                w_nxt_state = S_PERM;
                w_nxt_phase = PH_INIT;
                w_nxt_idx   = IDX_A;
            end
            // Every permutation ends on round index 11; only its start index differs.
            S_PERM: begin
                if (r_round_idx == IDX_LAST) begin
                    case (r_phase)
                        PH_INIT: w_nxt_state = w_aead ? S_KEYI : S_ABS;
                        PH_DATA: w_nxt_state = S_ABS;
                        default: w_nxt_state = S_SQZ;
                    endcase
                end else begin
                    w_nxt_idx = r_round_idx + 4'd1;
                end
            end
            S_KEYI: w_nxt_state = S_ABS;
            S_ABS: begin
                if (w_hs) begin
                    if (blk_last && w_aead) begin
                        w_nxt_state = S_KEYF;
                    end else begin
                        w_nxt_state = S_PERM;
                        w_nxt_phase = blk_last ? PH_SQZ : PH_DATA;
                        w_nxt_idx   = (w_aead && !blk_last) ? IDX_B : IDX_A;
                    end
                end
            end
            S_KEYF: begin
                w_nxt_state = S_PERM;
                w_nxt_phase = PH_SQZ;
                w_nxt_idx   = IDX_A;
            end
            S_SQZ: begin
                if (out_ready) begin
                    if (w_aead) begin
                        w_nxt_state = S_FIN;
                    end else begin
                        w_nxt_out_cnt = w_cnt_inc;
                        if (w_cnt_inc < N_OUT) begin
                            w_nxt_state = S_PERM;
                            w_nxt_phase = PH_SQZ;
                            w_nxt_idx   = IDX_A;
                        end else begin
                            w_nxt_state = S_FIN;
                        end
                    end
                end
            end
            S_FIN:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_phase         <= PH_INIT;
            r_mode          <= 3'd0;
            r_round_idx     <= 4'd0;
            r_out_cnt       <= 4'd0;
            r_busy          <= 1'b0;
            r_s_init        <= 1'b0;
            r_perm_en       <= 1'b0;
            r_key_xor_init  <= 1'b0;
            r_key_xor_final <= 1'b0;
            r_blk_ready     <= 1'b0;
            r_out_valid     <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_nxt_state;
            r_phase         <= w_nxt_phase;
            r_mode          <= w_nxt_mode;
            r_round_idx     <= w_nxt_idx;
            r_out_cnt       <= w_nxt_out_cnt;
            r_busy          <= (w_nxt_state != S_IDLE);
            r_s_init        <= (w_nxt_state == S_INIT);
            r_perm_en       <= (w_nxt_state == S_PERM);
            r_key_xor_init  <= (w_nxt_state == S_KEYI);
            r_key_xor_final <= (w_nxt_state == S_KEYF);
            r_blk_ready     <= (w_nxt_state == S_ABS);
            r_out_valid     <= (w_nxt_state == S_SQZ);
            r_done          <= (w_nxt_state == S_FIN);
            r_err           <= w_nxt_err;
        end
    end

    assign busy          = r_busy;
    assign s_init        = r_s_init;
    assign perm_en       = r_perm_en;
    assign round_idx     = r_round_idx;
    assign key_xor_init  = r_key_xor_init;
    assign key_xor_final = r_key_xor_final;
    assign blk_ready     = r_blk_ready;
    assign s_absorb      = blk_valid & r_blk_ready;
    assign out_valid     = r_out_valid;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Bench for ascon_sequencer: expected strobe sequence queued per operation, popped as the DUT emits strobes.
module tb_ascon_sequencer;

    localparam int RA  = 12;
    localparam int RB  = 8;
    localparam int HOB = 4;

    localparam int EV_INIT = 16;
    localparam int EV_PERM = 32;
    localparam int EV_KXI  = 48;
    localparam int EV_KXF  = 64;
    localparam int EV_ABS  = 80;
    localparam int EV_OUT  = 96;
    localparam int EV_DONE = 112;
    localparam int EV_ERR  = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] operation_mode;
    logic       start, blk_valid, blk_last, out_ready;
    logic       busy, s_init, perm_en, key_xor_init, key_xor_final;
    logic       blk_ready, s_absorb, out_valid, done, err;
    logic [3:0] round_idx;

    ascon_sequencer #(.ROUNDS_A(RA), .ROUNDS_B(RB), .HASH_OUT_BLOCKS(HOB)) dut (
        .clk(clk), .rst_n(rst_n), .operation_mode(operation_mode), .start(start),
        .blk_valid(blk_valid), .blk_last(blk_last), .out_ready(out_ready),
        .busy(busy), .s_init(s_init), .perm_en(perm_en), .round_idx(round_idx),
        .key_xor_init(key_xor_init), .key_xor_final(key_xor_final), .blk_ready(blk_ready),
        .s_absorb(s_absorb), .out_valid(out_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_q[$];
    int exp_perm;
    int n_perm, n_kx, n_out, n_done;
    int c_sinit, c_perm, c_kxi, c_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({busy, s_init, perm_en, round_idx, key_xor_init, key_xor_final,
                     blk_ready, s_absorb, out_valid, done, err});
    endfunction

    always @(negedge clk) begin
        int ev, hot;
        if (rst_n) begin
            ev  = -1;
            hot = int'(s_init) + int'(perm_en) + int'(key_xor_init) + int'(key_xor_final) + int'(s_absorb);
            if (hot != 0) chk("onehot", hot, 1);
            if (s_init) begin
                ev = EV_INIT;
                if (c_sinit < 0) c_sinit = cyc;
            end else if (perm_en) begin
                ev = EV_PERM + int'(round_idx);
                n_perm++;
                if (c_perm < 0) c_perm = cyc;
            end else if (key_xor_init) begin
                ev = EV_KXI;
                n_kx++;
                if (c_kxi < 0) c_kxi = cyc;
            end else if (key_xor_final) begin
                ev = EV_KXF;
                n_kx++;
            end else if (s_absorb) begin
                ev = EV_ABS;
            end else if (out_valid && out_ready) begin
                ev = EV_OUT;
                n_out++;
            end else if (done) begin
                ev = EV_DONE;
                n_done++;
            end else if (err) begin
                ev = EV_ERR;
            end
            if (blk_ready && c_rdy < 0) c_rdy = cyc;
            if (ev >= 0) begin
                if (exp_q.size() == 0) chk("unexp", ev, -1);
                else chk("seq", ev, exp_q.pop_front());
            end
        end
    end

    task automatic clr_mon();
        n_perm = 0; n_kx = 0; n_out = 0; n_done = 0;
        c_sinit = -1; c_perm = -1; c_kxi = -1; c_rdy = -1;
    endtask

    task automatic push_perm(input int r);
        for (int i = 0; i < r; i++) begin
            exp_q.push_back(EV_PERM + 12 - r + i);
            exp_perm++;
        end
    endtask

    task automatic push_op(input int mode, input int nblk);
        bit aead;
        int nout;
        exp_perm = 0;
        if (mode >= 6) begin
            exp_q.push_back(EV_ERR);
            return;
        end
        if (mode == 0) return;
        aead = (mode == 1 || mode == 2);
        nout = aead ? 1 : HOB;
        exp_q.push_back(EV_INIT);
        push_perm(RA);
        if (aead) exp_q.push_back(EV_KXI);
        for (int b = 0; b < nblk; b++) begin
            exp_q.push_back(EV_ABS);
            if (aead && b < nblk - 1) begin
                push_perm(RB);
            end else begin
                if (aead) exp_q.push_back(EV_KXF);
                push_perm(RA);
            end
        end
        for (int o = 0; o < nout; o++) begin
            exp_q.push_back(EV_OUT);
            if (o < nout - 1) push_perm(RA);
        end
        exp_q.push_back(EV_DONE);
    endtask

    task automatic run_op(input int mode, input int nblk, input int vgap, input int rgap, output int t0);
        int k;
        clr_mon();
        push_op(mode, nblk);
        operation_mode = 3'(mode);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (mode == 0 || mode >= 6) begin
            repeat (3) @(posedge clk);
            #1;
            chk("idle_busy", int'(busy), 0);
            return;
        end
        for (int b = 0; b < nblk; b++) begin
            k = 0;
            while (!blk_ready && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            if (!blk_ready) begin
                chk("to_rdy", 0, 1);
                return;
            end
            if (b == 0) begin
                for (int g = 0; g < vgap; g++) begin
                    chk("bp_rdy", int'(blk_ready), 1);
                    chk("bp_perm", int'(perm_en), 0);
                    @(posedge clk); #1;
                end
            end
            blk_valid = 1'b1;
            blk_last  = (b == nblk - 1);
            @(posedge clk); #1;
            blk_valid = 1'b0;
            blk_last  = 1'b0;
        end
        if (rgap > 0) begin
            out_ready = 1'b0;
            k = 0;
            while (!out_valid && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            if (!out_valid) chk("to_ov", 0, 1);
            for (int g = 0; g < rgap; g++) begin
                chk("bp_ov", int'(out_valid), 1);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        k = 0;
        while (!done && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_seen", int'(done), 1);
        @(posedge clk); #1;
        chk("busy_drop", int'(busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, k;
        rst_n = 1'b0; start = 1'b0; operation_mode = 3'd0;
        blk_valid = 1'b0; blk_last = 1'b0; out_ready = 1'b1;
        clr_mon();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AEAD encrypt, two blocks, exact cycle positions
        run_op(1, 2, 0, 0, t0);
        chk("enc_sinit", c_sinit - t0, 1);
        chk("enc_perm0", c_perm - t0, 2);
        chk("enc_kxi", c_kxi - t0, 14);
        chk("enc_rdy", c_rdy - t0, 15);
        chk("enc_nperm", n_perm, RA + RB + RA);
        chk("enc_nkx", n_kx, 2);
        chk("enc_nout", n_out, 1);
        chk("enc_ndone", n_done, 1);

        // Hash, one last block, four squeeze blocks
        run_op(3, 1, 0, 0, t0);
        chk("hash_rdy", c_rdy - t0, 14);
        chk("hash_nperm", n_perm, 12 + 12 + 36);
        chk("hash_nkx", n_kx, 0);
        chk("hash_nout", n_out, HOB);
        chk("hash_ndone", n_done, 1);

        // Decrypt with input and output backpressure
        run_op(2, 3, 10, 5, t0);
        chk("dec_nperm", n_perm, RA + 2 * RB + RA);
        chk("dec_nout", n_out, 1);

        // XOF and CXOF
        run_op(4, 2, 0, 0, t0);
        chk("xof_nperm", n_perm, exp_perm);
        run_op(5, 3, 3, 0, t0);
        chk("cxof_nout", n_out, HOB);

        // Illegal and null modes
        run_op(7, 0, 0, 0, t0);
        run_op(6, 0, 0, 0, t0);
        run_op(0, 0, 0, 0, t0);

        // Start and mode change while busy must not disturb the running operation
        fork
            run_op(1, 2, 0, 0, t0);
            begin
                repeat (6) @(posedge clk);
                #1;
                start = 1'b1;
                operation_mode = 3'd3;
                @(posedge clk); #1;
                start = 1'b0;
                operation_mode = 3'd6;
            end
        join
        chk("rerun_nperm", n_perm, exp_perm);
        chk("rerun_ndone", n_done, 1);

        // Reset in the middle of a permutation
        clr_mon();
        push_op(1, 2);
        operation_mode = 3'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!perm_en && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("mid_perm", int'(perm_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", all_outs(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_nodone", n_done, 0);

        chk("q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
